// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared constants for the calculator command path. It holds
//               the opcode bytes, the ALU operation encodings, the status
//               codes, the controller state encodings and the opcode decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

  // Command opcode bytes, given as their ASCII characters '+', '-', '*' and '/'
  localparam logic [7:0] OPC_ADD = 8'h2B;
  localparam logic [7:0] OPC_SUB = 8'h2D;
  localparam logic [7:0] OPC_MUL = 8'h2A;
  localparam logic [7:0] OPC_DIV = 8'h2F;

  // ALU operation select
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_MUL = 2'd2;
  localparam logic [1:0] ALU_DIV = 2'd3;

  // Status codes loaded into the output register on an error
  localparam logic [7:0] ST_BADOP   = 8'hE1;
  localparam logic [7:0] ST_ALUERR  = 8'hE2;
  localparam logic [7:0] ST_TIMEOUT = 8'hE3;

  // Controller states
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] GET_A    = 3'd1;
  localparam logic [2:0] GET_B    = 3'd2;
  localparam logic [2:0] START    = 3'd3;
  localparam logic [2:0] WAIT_ALU = 3'd4;
  localparam logic [2:0] LOAD_RES = 3'd5;
  localparam logic [2:0] LOAD_ERR = 3'd6;
  localparam logic [2:0] SEND     = 3'd7;

  typedef struct packed {
    logic       ok;  // byte is a recognised opcode
    logic [1:0] op;  // ALU operation; only meaningful when ok is set
  } opc_dec_t;

  function automatic opc_dec_t decode_opcode(input logic [7:0] b);
    opc_dec_t d;
    d.ok = 1'b1;
    d.op = ALU_ADD;
    case (b)
      OPC_ADD: d.op = ALU_ADD;
      OPC_SUB: d.op = ALU_SUB;
      OPC_MUL: d.op = ALU_MUL;
      OPC_DIV: d.op = ALU_DIV;
      default: d.ok = 1'b0;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : cmd_timeout_cnt
// Description : 8-bit saturating idle counter with clear and enable.
//               expired_o is high in the cycle whose enabled count would
//               reach TIMEOUT, so the caller can react on that same edge.
//               When TIMEOUT is 0, the counter is disabled.
// Ports       : clk_i     - clock
//               rst_ni    - synchronous active-low reset
//               clr_i     - clear the count (takes priority over en_i)
//               en_i      - count this cycle
//               expired_o - limit reached this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  // The counter is 8 bits wide, so any limit above 255 is reduced to 255.
  localparam int          LIMIT    = (TIMEOUT > 255) ? 255 : TIMEOUT;
  localparam logic [8:0]  LIMIT_W  = 9'(LIMIT);
  localparam logic        ENABLED  = (LIMIT != 0);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (en_i && ENABLED && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = ENABLED && en_i && !clr_i &&
                     (({1'b0, cnt_q} + 9'd1) >= LIMIT_W);

endmodule
`default_nettype wire

// File: rtl/cmd_interp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cmd_interp_ctrl
// Description : Sequencing controller for the calculator command path. It
//               receives an opcode/A/B byte triple, runs one ALU operation,
//               and then steers the external output register. load1 loads the
//               ALU result and load2 loads status_code_o. After the load it
//               hands the register to the transmitter over tx_valid/tx_ready.
// Ports       : clk_i, rst_ni             - clock, sync active-low reset
//               rx_data/valid_i, rx_ready_o - command byte handshake
//               alu_a/b/op_o, alu_start_o - ALU operands and launch pulse
//               alu_done_i, alu_err_i     - ALU completion and error flag
//               status_code_o             - error code for output register
//               load1_o, load2_o          - output register load selects
//               tx_valid_o, tx_ready_i    - transmit handshake
//               busy_o                    - controller not idle
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_interp_ctrl
  import calc_pkg::*;
#(
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [DW-1:0] rx_data_i,
  input  logic          rx_valid_i,
  output logic          rx_ready_o,
  output logic [DW-1:0] alu_a_o,
  output logic [DW-1:0] alu_b_o,
  output logic [1:0]    alu_op_o,
  output logic          alu_start_o,
  input  logic          alu_done_i,
  input  logic          alu_err_i,
  output logic [DW-1:0] status_code_o,
  output logic          load1_o,
  output logic          load2_o,
  output logic          tx_valid_o,
  input  logic          tx_ready_i,
  output logic          busy_o
);

  logic [2:0]    state_q,  state_d;
  logic [DW-1:0] alu_a_q,  alu_a_d;
  logic [DW-1:0] alu_b_q,  alu_b_d;
  logic [1:0]    alu_op_q, alu_op_d;
  logic [DW-1:0] status_q, status_d;

  logic     xfer;
  logic     in_get;
  logic     expired;
  opc_dec_t dec;

  assign rx_ready_o = (state_q == IDLE) || (state_q == GET_A) || (state_q == GET_B);
  assign xfer       = rx_valid_i && rx_ready_o;
  assign in_get     = (state_q == GET_A) || (state_q == GET_B);
  assign dec        = decode_opcode(rx_data_i[7:0]);

  // The counter runs only while the controller waits between operand bytes.
  // Any accepted byte restarts it.
  cmd_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (xfer),
    .en_i      (in_get && !xfer),
    .expired_o (expired)
  );

  always_comb begin
    state_d  = state_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    status_d = status_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (dec.ok) begin
            alu_op_d = dec.op;
            state_d  = GET_A;
          end else begin
            status_d = DW'(ST_BADOP);
            state_d  = LOAD_ERR;
          end
        end
      end
      GET_A: begin
        if (xfer) begin
          alu_a_d = rx_data_i;
          state_d = GET_B;
        end else if (expired) begin
          status_d = DW'(ST_TIMEOUT);
          state_d  = LOAD_ERR;
        end
      end
      GET_B: begin
        if (xfer) begin
          alu_b_d = rx_data_i;
          state_d = START;
        end else if (expired) begin
          status_d = DW'(ST_TIMEOUT);
          state_d  = LOAD_ERR;
        end
      end
      START:    state_d = WAIT_ALU;
      WAIT_ALU: begin
        // The error flag takes precedence, so a failed operation never loads
        // the result path.
        if (alu_done_i) begin
          if (alu_err_i) begin
            status_d = DW'(ST_ALUERR);
            state_d  = LOAD_ERR;
          end else begin
            state_d = LOAD_RES;
          end
        end
      end
      LOAD_RES: state_d = SEND;
      LOAD_ERR: state_d = SEND;
      SEND: begin
        if (tx_ready_i) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= 2'd0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      status_q <= status_d;
    end
  end

  // The outputs are decoded from the state only. Each load state lasts one
  // cycle, so load1 and load2 can never be high together.
  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign alu_op_o      = alu_op_q;
  assign status_code_o = status_q;
  assign alu_start_o   = (state_q == START);
  assign load1_o       = (state_q == LOAD_RES);
  assign load2_o       = (state_q == LOAD_ERR);
  assign tx_valid_o    = (state_q == SEND);
  assign busy_o        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cmd_interp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_interp_ctrl
// Description : Directed self-checking bench for cmd_interp_ctrl. It runs
//               with TIMEOUT=16 and includes a model of the external output
//               register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_interp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] alu_a, alu_b;
  logic [1:0] alu_op;
  logic       alu_start;
  logic       alu_done = 1'b0;
  logic       alu_err = 1'b0;
  logic [7:0] status_code;
  logic       load1, load2, tx_valid;
  logic       tx_ready = 1'b0;
  logic       busy;
  logic [7:0] alu_res = 8'h00;
  logic [7:0] out_reg = 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // External output register: in1 = ALU result, in2 = status code
  always @(posedge clk) begin
    if (load1)      out_reg <= alu_res;
    else if (load2) out_reg <= status_code;
  end

  cmd_interp_ctrl #(
    .DW      (8),
    .TIMEOUT (16)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .rx_data_i     (rx_data),
    .rx_valid_i    (rx_valid),
    .rx_ready_o    (rx_ready),
    .alu_a_o       (alu_a),
    .alu_b_o       (alu_b),
    .alu_op_o      (alu_op),
    .alu_start_o   (alu_start),
    .alu_done_i    (alu_done),
    .alu_err_i     (alu_err),
    .status_code_o (status_code),
    .load1_o       (load1),
    .load2_o       (load2),
    .tx_valid_o    (tx_valid),
    .tx_ready_i    (tx_ready),
    .busy_o        (busy)
  );

  // Advance one clock and sample 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte for a single cycle; the caller expects it to be accepted
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
    n_cmp++; if ({busy, alu_start, load1, load2, tx_valid} !== 5'b0) begin n_err++; $display("FAIL reset_ctrl: got %b want 00000", {busy, alu_start, load1, load2, tx_valid}); end
    n_cmp++; if ({alu_a, alu_b, alu_op, status_code} !== 26'h0) begin n_err++; $display("FAIL reset_regs: got %h want 0", {alu_a, alu_b, alu_op, status_code}); end
  endtask

  task automatic test_add();
    send_byte(8'h2B);
    send_byte(8'h05);
    send_byte(8'h03);
    // START
    n_cmp++; if (alu_start !== 1'b1) begin n_err++; $display("FAIL add_start: got %b want 1", alu_start); end
    n_cmp++; if ({alu_op, alu_a, alu_b} !== {2'd0, 8'h05, 8'h03}) begin n_err++; $display("FAIL add_operands: got op=%0d a=%h b=%h want op=0 a=05 b=03", alu_op, alu_a, alu_b); end
    n_cmp++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL add_rx_ready_start: got %b want 0", rx_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (alu_start !== 1'b0 || load1 !== 1'b0) begin n_err++; $display("FAIL add_wait_%0d: got start=%b load1=%b want 0 0", i, alu_start, load1); end
    end
    alu_res  = 8'h08;
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    tx_ready = 1'b1;
    // LOAD_RES
    n_cmp++; if ({load1, load2, tx_valid} !== 3'b100) begin n_err++; $display("FAIL add_load: got %b want 100", {load1, load2, tx_valid}); end
    tick();
    // SEND
    n_cmp++; if ({load1, tx_valid} !== 2'b01) begin n_err++; $display("FAIL add_send: got %b want 01", {load1, tx_valid}); end
    n_cmp++; if (out_reg !== 8'h08) begin n_err++; $display("FAIL add_out: got %h want 08", out_reg); end
    tick();
    n_cmp++; if ({busy, tx_valid, rx_ready} !== 3'b001) begin n_err++; $display("FAIL add_idle: got %b want 001", {busy, tx_valid, rx_ready}); end
    tx_ready = 1'b0;
  endtask

  task automatic test_bad_opcode();
    send_byte(8'h41);
    n_cmp++; if ({alu_start, load1, load2} !== 3'b001) begin n_err++; $display("FAIL bad_load: got %b want 001", {alu_start, load1, load2}); end
    n_cmp++; if (status_code !== 8'hE1) begin n_err++; $display("FAIL bad_status: got %h want e1", status_code); end
    tick();
    n_cmp++; if ({load2, tx_valid} !== 2'b01 || out_reg !== 8'hE1) begin n_err++; $display("FAIL bad_send: got load2/txv=%b out=%h want 01 e1", {load2, tx_valid}, out_reg); end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    n_cmp++; if ({busy, tx_valid} !== 2'b00) begin n_err++; $display("FAIL bad_idle: got %b want 00", {busy, tx_valid}); end
  endtask

  task automatic test_alu_err();
    send_byte(8'h2F);
    send_byte(8'h07);
    send_byte(8'h00);
    n_cmp++; if ({alu_start, alu_op, alu_a, alu_b} !== {1'b1, 2'd3, 8'h07, 8'h00}) begin n_err++; $display("FAIL err_start: got start=%b op=%0d a=%h b=%h want 1 3 07 00", alu_start, alu_op, alu_a, alu_b); end
    tick();
    alu_res  = 8'hFF;
    alu_done = 1'b1;
    alu_err  = 1'b1;
    tick();
    alu_done = 1'b0;
    alu_err  = 1'b0;
    n_cmp++; if ({load1, load2} !== 2'b01 || status_code !== 8'hE2) begin n_err++; $display("FAIL err_load: got l1l2=%b st=%h want 01 e2", {load1, load2}, status_code); end
    tick();
    n_cmp++; if (tx_valid !== 1'b1 || out_reg !== 8'hE2) begin n_err++; $display("FAIL err_send: got txv=%b out=%h want 1 e2", tx_valid, out_reg); end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL err_idle: got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    // Only the opcode is sent, so the timeout fires 16 edges later.
    send_byte(8'h2A);
    for (int k = 1; k <= 15; k++) begin
      tick();
      n_cmp++; if ({load2, rx_ready} !== 2'b01) begin n_err++; $display("FAIL to_wait_%0d: got l2/rdy=%b want 01", k, {load2, rx_ready}); end
    end
    tick();
    n_cmp++; if (load2 !== 1'b1 || status_code !== 8'hE3) begin n_err++; $display("FAIL to_fire: got l2=%b st=%h want 1 e3", load2, status_code); end
    tick();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL to_idle: got %b want 0", busy); end

    // A byte accepted at the 15th edge restarts the count.
    send_byte(8'h2A);
    for (int k = 1; k <= 14; k++) tick();
    send_byte(8'h01);
    n_cmp++; if ({load2, rx_ready, alu_a} !== {1'b0, 1'b1, 8'h01}) begin n_err++; $display("FAIL to_restart: got l2=%b rdy=%b a=%h want 0 1 01", load2, rx_ready, alu_a); end
    for (int k = 1; k <= 15; k++) begin
      tick();
      n_cmp++; if ({load2, rx_ready} !== 2'b01) begin n_err++; $display("FAIL to_rewait_%0d: got l2/rdy=%b want 01", k, {load2, rx_ready}); end
    end
    tick();
    n_cmp++; if (load2 !== 1'b1) begin n_err++; $display("FAIL to_refire: got %b want 1", load2); end
    tick();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    send_byte(8'h2B);
    send_byte(8'h10);
    send_byte(8'h20);
    tick();
    alu_res  = 8'h30;
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    tick();
    // SEND is held with tx_ready low while a byte is offered.
    rx_data  = 8'h2B;
    rx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if ({tx_valid, rx_ready, busy} !== 3'b101) begin n_err++; $display("FAIL bp_hold_%0d: got txv/rdy/busy=%b want 101", i, {tx_valid, rx_ready, busy}); end
      tick();
    end
    rx_valid = 1'b0;
    n_cmp++; if (status_code !== 8'hE3) begin n_err++; $display("FAIL bp_status_hold: got %h want e3", status_code); end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    n_cmp++; if ({busy, tx_valid} !== 2'b00 || out_reg !== 8'h30) begin n_err++; $display("FAIL bp_done: got busy/txv=%b out=%h want 00 30", {busy, tx_valid}, out_reg); end
  endtask

  task automatic test_reset_midop();
    send_byte(8'h2D);
    send_byte(8'h09);
    send_byte(8'h04);
    tick();
    // WAIT_ALU
    n_cmp++; if ({busy, alu_op} !== {1'b1, 2'd1}) begin n_err++; $display("FAIL rm_wait: got busy=%b op=%0d want 1 1", busy, alu_op); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++; if ({busy, rx_ready, tx_valid, load1, load2} !== 5'b01000) begin n_err++; $display("FAIL rm_idle: got %b want 01000", {busy, rx_ready, tx_valid, load1, load2}); end
    n_cmp++; if ({alu_a, alu_b, alu_op, status_code} !== 26'h0) begin n_err++; $display("FAIL rm_regs: got %h want 0", {alu_a, alu_b, alu_op, status_code}); end
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({load1, load2, busy} !== 3'b000) begin n_err++; $display("FAIL rm_late_done_%0d: got %b want 000", i, {load1, load2, busy}); end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_add();
    test_bad_opcode();
    test_alu_err();
    test_timeout();
    test_backpressure();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
